overlay_pixel_engines: RTL and testbench
========================================

Name: overlay_pixel_engines

Overview:
- Write-side pixel engines for the 640x480, 3-bit-colour frame-buffer overlay.
- Three independent channels:
  - char-cell index to top-left pixel address converter;
  - 8x8 glyph typer that paints one character cell;
  - trajectory dot drawer that paints a 2x2 dot.
- Each channel drives its own write port (waddr/wdata/wenable). The surrounding sequencer muxes those ports onto the frame-buffer write port and drives the start/finish handshakes.

Parameters:
- SCREEN_W, 640, pixels per line; address = y*SCREEN_W + x.
- SCREEN_PIX, 307200, total pixels; addresses >= this are never written.
- TEXT_COLS, 32, character cells per text row (8 text rows, 256 cells).
- TEXT_FG, 3'b111, colour of set glyph bits.
- TEXT_BG, 3'b000, colour of clear glyph bits.
- DOT_COLOR, 3'b010, trajectory dot colour.
- FONT_FILE, "font8x8.hex", hex init file for the font ROM.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- char_index  in  8  screen character index.
- char_addr  out  19  top-left pixel address of char_index's cell.
- typ_top_left  in  19  cell top-left address for the glyph typer.
- typ_char  in  8  character code to paint.
- typ_start  in  1  start request, sampled only while typ_finish=1.
- typ_finish  out  1  high = idle/ready; low while painting.
- typ_waddr  out  19  typer write address.
- typ_wdata  out  3  typer write colour.
- typ_wenable  out  1  typer write strobe.
- drw_pixeladdr  in  19  dot origin pixel address (top-left of the 2x2 dot).
- drw_start  in  1  start request, sampled only while drw_finish=1.
- drw_finish  out  1  high = idle/ready.
- drw_waddr  out  19  drawer write address.
- drw_wdata  out  3  drawer write colour.
- drw_wenable  out  1  drawer write strobe.

Behaviour:
- Reset:
  - char_addr=0; both finish outputs = 1; all waddr/wdata = 0; both wenable = 0.
  - Any in-progress job is aborted and the engine is idle on the next cycle.
- Converter: registered, latency 1.
  - col = char_index[4:0], row = char_index[7:5].
  - char_addr = row*8*SCREEN_W + col*8.
  - Index 255 gives 7*5120 + 248 = 36088.
- Font ROM:
  - 2048x8, loaded from FONT_FILE, read asynchronously.
  - Row byte at {char, glyph_row[2:0]}; bit 7 is the leftmost pixel.
- Typer FSM (IDLE -> PAINT -> IDLE):
  - In IDLE with typ_start=1: latch typ_top_left and typ_char, and set typ_finish=0 on the next edge.
  - PAINT lasts exactly 64 cycles. In cycle k (k=0..63), r=k[5:3], c=k[2:0]:
    - waddr = top + r*640 + c;
    - wdata = TEXT_FG if font bit (7-c) of row r is set, else TEXT_BG;
    - wenable = 1, except 0 when waddr >= SCREEN_PIX.
  - After the 64th write: wenable=0 and typ_finish=1 (IDLE).
  - typ_start while busy is ignored.
  - A start that is still high at the IDLE return launches a new job.
- Drawer FSM (IDLE -> DOT -> IDLE):
  - In IDLE with drw_start=1: latch drw_pixeladdr, drw_finish=0.
  - DOT lasts 4 cycles, writing p, p+1, p+640, p+641 in that order.
    - wdata = DOT_COLOR.
    - wenable = 1 unless the address is >= SCREEN_PIX (that cycle is suppressed but still consumed).
  - No horizontal clipping: x=639 wraps into the next line.
  - Then IDLE with drw_finish=1 and wenable=0.
- Arithmetic: 19-bit unsigned; sums that exceed 19 bits are out of range and are suppressed.
- Channels are fully independent and may run concurrently.

Decomposition:
- Shared package:
  - SCREEN_W, SCREEN_PIX, colour constants;
  - a typedef for the 19-bit pixel address;
  - a typedef for the 3-bit colour.
- One natural sub-module: overlay_glyph_typer (FSM plus font ROM).
- The converter and drawer stay inline.

Test Plan:
- Reset then idle -> typ_finish=1, drw_finish=1, both wenable=0, char_addr=0 one cycle after char_index=0.
- char_index=33 (row 1, col 1) -> char_addr=5128 one cycle later; char_index=255 -> 36088.
- Typer, top_left=5128, font row 0 = 8'h80 and other rows 0, one-cycle start:
  - finish low exactly 64 cycles, 64 consecutive writes;
  - first write at 5128 with 3'b111; next 63 writes 3'b000;
  - last write at 5128 + 7*640 + 7 = 9615.
- Drawer, pixeladdr=1000, one-cycle start -> writes 1000, 1001, 1640, 1641 with 3'b010, finish low 4 cycles.
- Drawer, pixeladdr=307000 -> writes 307000 and 307001; the cycles for 307640 and 307641 have wenable=0; finish still returns after 4 cycles.
- reset asserted mid-typer job (cycle 30) -> next cycle wenable=0 and typ_finish=1; a fresh start repaints all 64 pixels.

Source files
------------

// File: rtl/overlay_pixel_engines_pkg.sv
// rtl/overlay_pixel_engines_pkg.sv - shared constants, types and address helpers for the overlay pixel engines
package overlay_pixel_engines_pkg;

    localparam int SCREEN_W    = 640;
    localparam int SCREEN_PIX  = 307200;
    localparam int TEXT_COLS   = 32;
    localparam int FONT_BITS_W = 2048 * 8;

    typedef logic [18:0] pix_addr_t;
    typedef logic [2:0]  color_t;

    localparam color_t TEXT_FG   = 3'b111;
    localparam color_t TEXT_BG   = 3'b000;
    localparam color_t DOT_COLOR = 3'b010;

    // One extra bit so that sums running past 19 bits stay visibly off-screen.
    function automatic logic [19:0] pix_offset(input pix_addr_t base, input logic [2:0] r,
                                               input logic [2:0] c);
        return {1'b0, base} + 20'(r) * 20'(SCREEN_W) + 20'(c);
    endfunction

    function automatic logic on_screen(input logic [19:0] addr);
        return addr < 20'(SCREEN_PIX);
    endfunction

endpackage

// File: rtl/overlay_glyph_typer.sv
// rtl/overlay_glyph_typer.sv - paints one 8x8 character cell from the font ROM, one pixel per cycle
module overlay_glyph_typer
    import overlay_pixel_engines_pkg::*;
#(
    parameter logic [FONT_BITS_W-1:0] FONT_BITS = '0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [18:0] top_left,
    input  logic [7:0]  char_code,
    input  logic        start,
    output logic        finish,
    output logic [18:0] waddr,
    output logic [2:0]  wdata,
    output logic        wenable
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] PAINT = 1'b1;

    logic [0:0]  state;
    logic [5:0]  step;
    pix_addr_t   top;
    logic [7:0]  chr;
    logic [7:0]  row_byte;
    logic [19:0] addr_full;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            step  <= '0;
            top   <= '0;
            chr   <= '0;
        end else if (state == IDLE) begin
            if (start) begin
                state <= PAINT;
                step  <= '0;
                top   <= top_left;
                chr   <= char_code;
            end
        end else begin
            step <= step + 6'd1;
            if (step == 6'd63) state <= IDLE;
        end
    end

    // Font byte for (char, glyph row); bit 7 is the leftmost pixel of the row.
    assign row_byte  = FONT_BITS[{chr, step[5:3], 3'b000} +: 8];
    assign addr_full = pix_offset(top, step[5:3], step[2:0]);

    assign finish  = (state == IDLE);
    assign waddr   = (state == PAINT) ? addr_full[18:0] : '0;
    assign wdata   = (state == PAINT) ? (row_byte[3'd7 - step[2:0]] ? TEXT_FG : TEXT_BG) : '0;
    assign wenable = (state == PAINT) && on_screen(addr_full);

endmodule

// File: rtl/overlay_pixel_engines.sv
// rtl/overlay_pixel_engines.sv - char-cell address converter, glyph typer and 2x2 trajectory dot drawer
module overlay_pixel_engines
    import overlay_pixel_engines_pkg::*;
#(
    parameter logic [FONT_BITS_W-1:0] FONT_BITS = '0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  char_index,
    output logic [18:0] char_addr,
    input  logic [18:0] typ_top_left,
    input  logic [7:0]  typ_char,
    input  logic        typ_start,
    output logic        typ_finish,
    output logic [18:0] typ_waddr,
    output logic [2:0]  typ_wdata,
    output logic        typ_wenable,
    input  logic [18:0] drw_pixeladdr,
    input  logic        drw_start,
    output logic        drw_finish,
    output logic [18:0] drw_waddr,
    output logic [2:0]  drw_wdata,
    output logic        drw_wenable
);

    localparam int COL_BITS = $clog2(TEXT_COLS);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] DOT  = 1'b1;

    logic [COL_BITS-1:0] cell_col;
    logic [7-COL_BITS:0] cell_row;

    assign cell_col = char_index[COL_BITS-1:0];
    assign cell_row = char_index[7:COL_BITS];

    always_ff @(posedge clock) begin
        if (reset) char_addr <= '0;
        else       char_addr <= pix_addr_t'(cell_row) * pix_addr_t'(8 * SCREEN_W)
                              + pix_addr_t'(cell_col) * pix_addr_t'(8);
    end

    overlay_glyph_typer #(
        .FONT_BITS (FONT_BITS)
    ) u_typer (
        .clock     (clock),
        .reset     (reset),
        .top_left  (typ_top_left),
        .char_code (typ_char),
        .start     (typ_start),
        .finish    (typ_finish),
        .waddr     (typ_waddr),
        .wdata     (typ_wdata),
        .wenable   (typ_wenable)
    );

    logic [0:0]  drw_state;
    logic [1:0]  drw_step;
    pix_addr_t   drw_origin;
    logic [19:0] drw_full;

    always_ff @(posedge clock) begin
        if (reset) begin
            drw_state  <= IDLE;
            drw_step   <= '0;
            drw_origin <= '0;
        end else if (drw_state == IDLE) begin
            if (drw_start) begin
                drw_state  <= DOT;
                drw_step   <= '0;
                drw_origin <= drw_pixeladdr;
            end
        end else begin
            drw_step <= drw_step + 2'd1;
            if (drw_step == 2'd3) drw_state <= IDLE;
        end
    end

    // Step bit 1 selects the lower line, bit 0 the right column: p, p+1, p+640, p+641.
    assign drw_full = pix_offset(drw_origin, {2'b00, drw_step[1]}, {2'b00, drw_step[0]});

    assign drw_finish  = (drw_state == IDLE);
    assign drw_waddr   = (drw_state == DOT) ? drw_full[18:0] : '0;
    assign drw_wdata   = (drw_state == DOT) ? DOT_COLOR : '0;
    assign drw_wenable = (drw_state == DOT) && on_screen(drw_full);

endmodule

// File: tb/tb_overlay_pixel_engines.sv
// tb/tb_overlay_pixel_engines.sv - randomized scoreboard bench for the overlay pixel engines
module tb_overlay_pixel_engines;
    import overlay_pixel_engines_pkg::*;

    // Sixteen distinct glyphs repeated across the font; char 0 is row0=8'h80, rest blank.
    localparam logic [1023:0] BLK = {
        64'h3C66C3FFC3C3C300, 64'hFE6363FE6363FE00, 64'h1E3363030363331E, 64'hF86C6666666CF800,
        64'hA55AA55AA55AA55A, 64'h0102040810204080, 64'h8040201008040201, 64'hFF818181818181FF,
        64'h00183C7E7E3C1800, 64'hF0F0F0F00F0F0F0F, 64'h1122448811224488, 64'h7E00FF00FF007E00,
        64'hC3E77E3C3C7EE7C3, 64'h0F1E3C78F0E1C387, 64'h5555AAAA5555AAAA, 64'h9966996699669966};
    localparam logic [FONT_BITS_W-1:0] TB_FONT = {{15{BLK}}, BLK[1023:64], 64'h0000000000000080};

    logic        clock;
    logic        reset;
    logic [7:0]  char_index;
    logic [18:0] char_addr;
    logic [18:0] typ_top_left;
    logic [7:0]  typ_char;
    logic        typ_start;
    logic        typ_finish;
    logic [18:0] typ_waddr;
    logic [2:0]  typ_wdata;
    logic        typ_wenable;
    logic [18:0] drw_pixeladdr;
    logic        drw_start;
    logic        drw_finish;
    logic [18:0] drw_waddr;
    logic [2:0]  drw_wdata;
    logic        drw_wenable;

    overlay_pixel_engines #(
        .FONT_BITS (TB_FONT)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .char_index    (char_index),
        .char_addr     (char_addr),
        .typ_top_left  (typ_top_left),
        .typ_char      (typ_char),
        .typ_start     (typ_start),
        .typ_finish    (typ_finish),
        .typ_waddr     (typ_waddr),
        .typ_wdata     (typ_wdata),
        .typ_wenable   (typ_wenable),
        .drw_pixeladdr (drw_pixeladdr),
        .drw_start     (drw_start),
        .drw_finish    (drw_finish),
        .drw_waddr     (drw_waddr),
        .drw_wdata     (drw_wdata),
        .drw_wenable   (drw_wenable)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    logic [21:0] exp_typ[$];
    logic [21:0] exp_drw[$];
    int typ_len_q[$];
    int drw_len_q[$];
    int typ_low = 0;
    int drw_low = 0;

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // Monitor: pops the expected write stream and busy lengths whenever the DUT shows them.
    initial begin
        logic [21:0] e;
        forever begin
            @(negedge clock);
            if (!reset) begin
                if (typ_wenable) begin
                    if (exp_typ.size() == 0) check("typ_unexpected_write", typ_waddr, -1);
                    else begin
                        e = exp_typ.pop_front();
                        check("typ_waddr", typ_waddr, e[21:3]);
                        check("typ_wdata", typ_wdata, e[2:0]);
                    end
                end
                if (!typ_finish) typ_low++;
                else if (typ_low != 0) begin
                    if (typ_len_q.size() == 0) check("typ_unexpected_job", typ_low, 0);
                    else check("typ_busy_cycles", typ_low, typ_len_q.pop_front());
                    typ_low = 0;
                end
                if (drw_wenable) begin
                    if (exp_drw.size() == 0) check("drw_unexpected_write", drw_waddr, -1);
                    else begin
                        e = exp_drw.pop_front();
                        check("drw_waddr", drw_waddr, e[21:3]);
                        check("drw_wdata", drw_wdata, e[2:0]);
                    end
                end
                if (!drw_finish) drw_low++;
                else if (drw_low != 0) begin
                    if (drw_len_q.size() == 0) check("drw_unexpected_job", drw_low, 0);
                    else check("drw_busy_cycles", drw_low, drw_len_q.pop_front());
                    drw_low = 0;
                end
            end
        end
    end

    task automatic conv(input logic [7:0] idx);
        char_index = idx;
        @(posedge clock); #1;
        check("char_addr", char_addr, (int'(idx) / 32) * 5120 + (int'(idx) % 32) * 8);
    endtask

    task automatic wait_typ_ready();
        int n = 0;
        while (!typ_finish && n < 200) begin @(posedge clock); #1; n++; end
        if (!typ_finish) check("typ_ready_timeout", 0, 1);
    endtask

    task automatic wait_drw_ready();
        int n = 0;
        while (!drw_finish && n < 20) begin @(posedge clock); #1; n++; end
        if (!drw_finish) check("drw_ready_timeout", 0, 1);
    endtask

    task automatic typ_model(input logic [18:0] top, input logic [7:0] ch);
        for (int r = 0; r < 8; r++) begin
            logic [7:0] row;
            row = TB_FONT[(int'(ch) * 8 + r) * 8 +: 8];
            for (int c = 0; c < 8; c++) begin
                int a;
                a = int'(top) + r * SCREEN_W + c;
                if (a < SCREEN_PIX) exp_typ.push_back({19'(a), row[7 - c] ? TEXT_FG : TEXT_BG});
            end
        end
        typ_len_q.push_back(64);
    endtask

    task automatic drw_model(input logic [18:0] p);
        int offs[4] = '{0, 1, 640, 641};
        for (int i = 0; i < 4; i++) begin
            int a;
            a = int'(p) + offs[i];
            if (a < SCREEN_PIX) exp_drw.push_back({19'(a), DOT_COLOR});
        end
        drw_len_q.push_back(4);
    endtask

    // Start stays high when hold=1 so the next job launches on the idle return.
    task automatic typ_job(input logic [18:0] top, input logic [7:0] ch, input bit hold);
        typ_top_left = top;
        typ_char     = ch;
        typ_start    = 1'b1;
        wait_typ_ready();
        typ_model(top, ch);
        @(posedge clock); #1;
        if (!hold) typ_start = 1'b0;
    endtask

    task automatic drw_job(input logic [18:0] p, input bit hold);
        drw_pixeladdr = p;
        drw_start     = 1'b1;
        wait_drw_ready();
        drw_model(p);
        @(posedge clock); #1;
        if (!hold) drw_start = 1'b0;
    endtask

    function automatic logic [18:0] rand_addr();
        case ($urandom_range(0, 2))
            0:       return 19'($urandom_range(0, SCREEN_PIX - 1));
            1:       return 19'($urandom_range(SCREEN_PIX - 5000, SCREEN_PIX - 1));
            default: return 19'($urandom);
        endcase
    endfunction

    initial begin
        reset = 1'b1;
        char_index = '0;
        typ_top_left = '0;
        typ_char = '0;
        typ_start = 1'b0;
        drw_pixeladdr = '0;
        drw_start = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        check("reset_typ_finish", typ_finish, 1);
        check("reset_drw_finish", drw_finish, 1);
        check("reset_typ_wenable", typ_wenable, 0);
        check("reset_drw_wenable", drw_wenable, 0);
        check("reset_char_addr", char_addr, 0);
        check("reset_typ_waddr", typ_waddr, 0);

        conv(8'd0);
        conv(8'd33);
        conv(8'd255);
        for (int i = 0; i < 6; i++) conv(8'($urandom));

        typ_job(19'd5128, 8'd0, 1'b0);
        wait_typ_ready();
        drw_job(19'd1000, 1'b0);
        drw_job(19'd307000, 1'b0);
        wait_drw_ready();

        typ_job(19'd5128, 8'd0, 1'b0);
        repeat (30) begin @(posedge clock); #1; end
        reset = 1'b1;
        @(posedge clock); #1;
        exp_typ.delete();
        typ_len_q.delete();
        typ_low = 0;
        reset = 1'b0;
        @(negedge clock);
        check("abort_typ_wenable", typ_wenable, 0);
        check("abort_typ_finish", typ_finish, 1);
        check("abort_drw_finish", drw_finish, 1);
        @(posedge clock); #1;
        typ_job(19'd5128, 8'd0, 1'b0);
        wait_typ_ready();

        fork
            begin
                for (int j = 0; j < 12; j++) begin
                    bit hold;
                    hold = ($urandom_range(0, 3) == 0);
                    typ_job(rand_addr(), 8'($urandom), hold);
                    if (!hold) repeat ($urandom_range(0, 3)) begin @(posedge clock); #1; end
                end
                typ_start = 1'b0;
            end
            begin
                for (int j = 0; j < 30; j++) begin
                    bit hold;
                    hold = ($urandom_range(0, 3) == 0);
                    drw_job(rand_addr(), hold);
                    if (!hold) repeat ($urandom_range(0, 5)) begin @(posedge clock); #1; end
                end
                drw_start = 1'b0;
            end
        join
        wait_typ_ready();
        wait_drw_ready();
        repeat (3) @(posedge clock);
        #1;
        check("typ_writes_left", exp_typ.size(), 0);
        check("drw_writes_left", exp_drw.size(), 0);
        check("typ_jobs_left", typ_len_q.size(), 0);
        check("drw_jobs_left", drw_len_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
